// File: rtl/jpc_bitplane_coder_pkg.sv
// jpc_bitplane_coder_pkg: block geometry, context constants, FSM types and neighbour helpers
package jpc_bitplane_coder_pkg;
  localparam int W_WT1 = 8;
  localparam int BPC_WIDTH = 8;
  localparam int NN = BPC_WIDTH * BPC_WIDTH;
  localparam int IW = $clog2(NN);
  localparam int CB = $clog2(BPC_WIDTH);
  localparam int SB = $clog2(BPC_WIDTH / 4);
  localparam logic [4:0] CX_MR0 = 5'd14;
  localparam logic [4:0] CX_RL = 5'd17;
  localparam logic [4:0] CX_UNI = 5'd18;
  localparam logic [1:0] PASS_SPP = 2'd0;
  localparam logic [1:0] PASS_MRP = 2'd1;
  localparam logic [1:0] PASS_CUP = 2'd2;
  typedef enum logic [2:0] {LOAD, SPP, MRP, CUP, DONE} state_t;
  typedef enum logic [1:0] {SCAN, SIGN, UNI0, UNI1} step_t;
  // positions outside the code-block read as insignificant
  function automatic logic at(input logic [NN-1:0] a, input int y, input int x);
    if (y < 0 || y >= BPC_WIDTH || x < 0 || x >= BPC_WIDTH) return 1'b0;
    return a[IW'(y * BPC_WIDTH + x)];
  endfunction
  function automatic logic [3:0] hv4(input logic [NN-1:0] a, input int y, input int x);
    return {at(a, y + 1, x), at(a, y - 1, x), at(a, y, x + 1), at(a, y, x - 1)};
  endfunction
  function automatic logic [7:0] nbrs(input logic [NN-1:0] a, input int y, input int x);
    return {at(a, y + 1, x + 1), at(a, y + 1, x - 1), at(a, y - 1, x + 1), at(a, y - 1, x - 1), hv4(a, y, x)};
  endfunction
endpackage

// File: rtl/jpc_bitplane_coder_ctx_lut.sv
// jpc_bitplane_coder_ctx_lut: ZC/SC/MR context and sign xor-bit from the 8-neighbourhood
module jpc_bitplane_coder_ctx_lut
  import jpc_bitplane_coder_pkg::*;
(
  input  logic [7:0] nbr,
  input  logic [3:0] nsg,
  input  logic [1:0] band,
  input  logic       refined,
  output logic [4:0] zc_cx,
  output logic [4:0] sc_cx,
  output logic [4:0] mr_cx,
  output logic       sc_xr
);
  logic [1:0] h, v, hh, vv, hp, hn, vp, vn;
  logic [2:0] dg, hv;
  logic [4:0] zc_lh, zc_d;
  logic hpos, hneg, vpos, vneg;
  assign h = 2'(nbr[0]) + 2'(nbr[1]);
  assign v = 2'(nbr[2]) + 2'(nbr[3]);
  assign dg = 3'(nbr[4]) + 3'(nbr[5]) + 3'(nbr[6]) + 3'(nbr[7]);
  assign hv = 3'(h) + 3'(v);
  assign {hh, vv} = band == 2'd2 ? {v, h} : {h, v};
  assign zc_lh = hh == 2'd2 ? 5'd8 : hh == 2'd1 ? (vv != 2'd0 ? 5'd7 : dg != 3'd0 ? 5'd6 : 5'd5)
               : vv == 2'd2 ? 5'd4 : vv == 2'd1 ? 5'd3 : dg >= 3'd2 ? 5'd2 : dg == 3'd1 ? 5'd1 : 5'd0;
  assign zc_d = dg >= 3'd3 ? 5'd8 : dg == 3'd2 ? (hv != 3'd0 ? 5'd7 : 5'd6)
              : dg == 3'd1 ? (hv >= 3'd2 ? 5'd5 : hv == 3'd1 ? 5'd4 : 5'd3)
              : hv >= 3'd2 ? 5'd2 : hv == 3'd1 ? 5'd1 : 5'd0;
  assign zc_cx = band == 2'd3 ? zc_d : zc_lh;
  // nsg is already masked by significance, so it counts the negative neighbours
  assign hp = 2'(nbr[0] & ~nsg[0]) + 2'(nbr[1] & ~nsg[1]);
  assign hn = 2'(nsg[0]) + 2'(nsg[1]);
  assign vp = 2'(nbr[2] & ~nsg[2]) + 2'(nbr[3] & ~nsg[3]);
  assign vn = 2'(nsg[2]) + 2'(nsg[3]);
  assign {hpos, hneg, vpos, vneg} = {hp > hn, hn > hp, vp > vn, vn > vp};
  assign sc_cx = hpos | hneg ? (vpos | vneg ? (hpos == vpos ? 5'd13 : 5'd11) : 5'd12)
               : (vpos | vneg ? 5'd10 : 5'd9);
  assign sc_xr = hneg | (~hpos & vneg);
  assign mr_cx = refined ? CX_MR0 + 5'd2 : nbr != 8'd0 ? CX_MR0 + 5'd1 : CX_MR0;
endmodule

// File: rtl/jpc_bitplane_coder.sv
// jpc_bitplane_coder: EBCOT tier-1 bit-plane coder, one plane of one code-block per run
module jpc_bitplane_coder
  import jpc_bitplane_coder_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic [W_WT1:0] coeff0,
  input  logic [W_WT1:0] coeff1,
  input  logic [W_WT1:0] coeff2,
  input  logic [W_WT1:0] coeff3,
  input  logic           coef_en,
  input  logic           first_row,
  input  logic           first_col,
  input  logic           last_col,
  input  logic           first_plane,
  input  logic [1:0]     band,
  input  logic [3:0]     bit_pos,
  input  logic           mq_sig_e,
  input  logic           mq_ref_e,
  input  logic           mq_cln_e,
  output logic [9:0]     pp
);
  localparam int PW = SB + CB + 2;
  state_t st, st_d;
  step_t step, step_d;
  logic [PW-1:0] pos, pos_d, base;
  logic [SB-1:0] ps, ld_s, ls;
  logic [CB-1:0] pc, ld_c, lc;
  logic [1:0] pr, rl_row, rl_d, rl_first, pass;
  logic [IW-1:0] idx, sig_at, ri;
  logic [NN-1:0] sig, refd, vis, sgn, bitv;
  logic [W_WT1:0] cf [4];
  logic [7:0] nbr;
  logic [3:0] nsg, col_bits;
  logic [4:0] cx, zc_cx, sc_cx, mr_cx;
  logic fp, fp_eff, cur_sig, cur_vis, cur_bit, cur_sgn, sc_xr, rl_ok;
  logic vld, d, done, adv, skip, sig_we, vis_we, ref_we, en;
  assign cf = '{coeff0, coeff1, coeff2, coeff3};
  assign {ps, pc, pr} = pos;
  assign idx = {ps, pr, pc};
  assign {cur_sig, cur_vis, cur_bit, cur_sgn} = {sig[idx], vis[idx], bitv[idx], sgn[idx]};
  assign nbr = nbrs(sig, int'({ps, pr}), int'(pc));
  assign nsg = hv4(sgn, int'({ps, pr}), int'(pc)) & nbr[3:0];
  assign ls = first_row && first_col ? '0 : ld_s;
  assign lc = first_col ? '0 : ld_c;
  assign fp_eff = first_row && first_col ? first_plane : fp;
  assign pass = st == SPP ? PASS_SPP : st == MRP ? PASS_MRP : PASS_CUP;
  assign en = st == SPP ? mq_sig_e : st == MRP ? mq_ref_e : mq_cln_e;
  assign rl_first = col_bits[0] ? 2'd0 : col_bits[1] ? 2'd1 : col_bits[2] ? 2'd2 : 2'd3;
  jpc_bitplane_coder_ctx_lut u_lut (
    .nbr(nbr), .nsg(nsg), .band(band), .refined(refd[idx]),
    .zc_cx(zc_cx), .sc_cx(sc_cx), .mr_cx(mr_cx), .sc_xr(sc_xr)
  );
  // run-length eligibility: whole column uncoded, insignificant and with an all-zero neighbourhood
  always_comb begin
    rl_ok = 1'b1;
    col_bits = '0;
    ri = '0;
    for (int r = 0; r < 4; r++) begin
      ri = {ps, 2'(r), pc};
      rl_ok = rl_ok && !sig[ri] && !vis[ri] && nbrs(sig, int'({ps, 2'(r)}), int'(pc)) == 8'd0;
      col_bits[r] = bitv[ri];
    end
  end
  always_comb begin
    st_d = st;
    step_d = step;
    pos_d = pos;
    rl_d = rl_row;
    {vld, cx, d, done, adv, skip} = '0;
    {sig_we, vis_we, ref_we} = '0;
    sig_at = idx;
    case (st)
      LOAD: if (coef_en && last_col && &ls) begin
        st_d = fp_eff ? CUP : SPP;
        pos_d = '0;
        step_d = SCAN;
      end
      SPP: if (step == SIGN) begin
        {vld, cx, d, adv} = {1'b1, sc_cx, cur_sgn ^ sc_xr, 1'b1};
      end else if (!cur_sig && nbr != 8'd0) begin
        {vld, cx, d, vis_we, sig_we} = {1'b1, zc_cx, cur_bit, 1'b1, cur_bit};
        step_d = cur_bit ? SIGN : SCAN;
        adv = !cur_bit;
      end else adv = 1'b1;
      MRP: begin
        {vld, cx, d, ref_we} = {cur_sig && !cur_vis, mr_cx, cur_bit, cur_sig && !cur_vis};
        adv = 1'b1;
      end
      CUP: case (step)
        SIGN: {vld, cx, d, adv} = {1'b1, sc_cx, cur_sgn ^ sc_xr, 1'b1};
        UNI0: begin
          {vld, cx, d} = {1'b1, CX_UNI, rl_row[1]};
          step_d = UNI1;
        end
        UNI1: begin
          {vld, cx, d, sig_we} = {1'b1, CX_UNI, rl_row[0], 1'b1};
          sig_at = {ps, rl_row, pc};
          pos_d = {ps, pc, rl_row};
          step_d = SIGN;
        end
        default: if (pr == 2'd0 && rl_ok) begin
          {vld, cx, d} = {1'b1, CX_RL, |col_bits};
          rl_d = rl_first;
          step_d = |col_bits ? UNI0 : SCAN;
          {adv, skip} = {2{~|col_bits}};
        end else if (!cur_sig && !cur_vis) begin
          {vld, cx, d, sig_we} = {1'b1, zc_cx, cur_bit, cur_bit};
          step_d = cur_bit ? SIGN : SCAN;
          adv = !cur_bit;
        end else adv = 1'b1;
      endcase
      default: begin
        done = 1'b1;
        st_d = LOAD;
      end
    endcase
    base = skip ? pos | PW'(3) : pos;
    if (adv) begin
      pos_d = base + 1'b1;
      step_d = SCAN;
      if (&base) st_d = st == SPP ? MRP : st == MRP ? CUP : DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rstn) begin
      st <= LOAD;
      step <= SCAN;
      pos <= '0;
      rl_row <= '0;
      ld_s <= '0;
      ld_c <= '0;
      fp <= 1'b0;
      {sig, refd, vis, sgn, bitv} <= '0;
      pp <= '0;
    end else begin
      st <= st_d;
      step <= step_d;
      pos <= pos_d;
      rl_row <= rl_d;
      pp <= vld && en ? {2'b01, pass, cx, d} : {done, 9'd0};
      if (st == LOAD && coef_en) begin
        if (first_row && first_col) begin
          fp <= first_plane;
          vis <= '0;
          if (first_plane) {sig, refd} <= '0;
        end
        for (int r = 0; r < 4; r++) begin
          sgn[{ls, 2'(r), lc}] <= cf[r][W_WT1];
          bitv[{ls, 2'(r), lc}] <= cf[r][bit_pos];
        end
        ld_c <= lc + 1'b1;
        if (last_col) ld_s <= ls + 1'b1;
      end
      if (sig_we) sig[sig_at] <= 1'b1;
      if (vis_we) vis[idx] <= 1'b1;
      if (ref_we) refd[idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_jpc_bitplane_coder.sv
// tb_jpc_bitplane_coder: directed plane runs on an 8x8 block, symbol streams against hand-derived lists
module tb_jpc_bitplane_coder;
  logic clk = 1'b0;
  logic rstn, coef_en, first_row, first_col, last_col, first_plane;
  logic mq_sig_e, mq_ref_e, mq_cln_e;
  logic [8:0] coeff0, coeff1, coeff2, coeff3;
  logic [1:0] band;
  logic [3:0] bit_pos;
  logic [9:0] pp;
  logic [8:0] blk [8][8];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int checks = 0;
  int passes = 0;
  int dn;

  always #5 clk = ~clk;

  jpc_bitplane_coder dut (
    .clk(clk), .rstn(rstn), .coeff0(coeff0), .coeff1(coeff1), .coeff2(coeff2), .coeff3(coeff3),
    .coef_en(coef_en), .first_row(first_row), .first_col(first_col), .last_col(last_col),
    .first_plane(first_plane), .band(band), .bit_pos(bit_pos),
    .mq_sig_e(mq_sig_e), .mq_ref_e(mq_ref_e), .mq_cln_e(mq_cln_e), .pp(pp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic e(input int p, input int c, input int b);
    exp_q.push_back(8'(p * 64 + c * 2 + b));
  endtask

  task automatic rl(input int n);
    for (int i = 0; i < n; i++) e(2, 17, 0);
  endtask

  // MSB plane with only (0,0) set: RL hit, UNI 00, sign, then the rest of columns 0 and 1
  task automatic exp_p1(input bit hh, input bit neg);
    e(2, 17, 1); e(2, 18, 0); e(2, 18, 0); e(2, 9, int'(neg));
    e(2, hh ? 1 : 3, 0); e(2, 0, 0); e(2, 0, 0);
    e(2, hh ? 1 : 5, 0); e(2, hh ? 3 : 1, 0); e(2, 0, 0); e(2, 0, 0);
    rl(14);
  endtask

  task automatic exp_p2(input bit hh);
    e(0, hh ? 1 : 3, 0); e(0, hh ? 1 : 5, 0); e(0, hh ? 3 : 1, 0);
    e(1, 14, 1);
    e(2, 0, 0); e(2, 0, 0); e(2, 0, 0); e(2, 0, 0);
    rl(14);
  endtask

  task automatic clear_blk();
    for (int y = 0; y < 8; y++) for (int x = 0; x < 8; x++) blk[y][x] = '0;
  endtask

  task automatic load_plane(input bit fp, input int bp, input int bd);
    for (int s = 0; s < 2; s++) for (int c = 0; c < 8; c++) begin
      {coeff0, coeff1, coeff2, coeff3} = {blk[4*s][c], blk[4*s+1][c], blk[4*s+2][c], blk[4*s+3][c]};
      {coef_en, first_row, first_col, last_col, first_plane} = {1'b1, s == 0, c == 0, c == 7, fp};
      bit_pos = 4'(bp);
      band = 2'(bd);
      tick();
    end
    {coef_en, first_row, first_col, last_col} = '0;
  endtask

  task automatic run_plane(input bit noise, output int done_seen);
    got.delete();
    done_seen = 0;
    for (int k = 0; k < 400 && done_seen == 0; k++) begin
      if (noise) begin
        coef_en = 1'($urandom);
        {coeff0, coeff1, coeff2, coeff3} = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
        {first_row, first_col, last_col, first_plane} = 4'($urandom);
      end
      tick();
      if (pp[8]) got.push_back(pp[7:0]);
      if (pp[9]) done_seen = 1;
    end
    {coef_en, first_row, first_col, last_col} = '0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_sym%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    exp_q.delete();
  endtask

  initial begin
    {rstn, coef_en, first_row, first_col, last_col, first_plane} = '1;
    {mq_sig_e, mq_ref_e, mq_cln_e} = '1;
    band = 2'd0;
    bit_pos = 4'd7;
    for (int i = 0; i < 3; i++) begin
      {coeff0, coeff1, coeff2, coeff3} = {9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom)};
      tick();
      chk($sformatf("reset_pp%0d", i), 32'(pp), 32'd0);
    end
    {rstn, coef_en, first_row, first_col, last_col} = '0;
    tick();
    chk("post_reset_pp", 32'(pp), 32'd0);

    clear_blk();
    load_plane(1'b1, 7, 0);
    run_plane(1'b0, dn);
    chk("zero_done", 32'(dn), 32'd1);
    rl(16);
    compare("zero");
    tick();
    chk("zero_idle", 32'(pp), 32'd0);

    blk[0][0] = 9'h080;
    load_plane(1'b1, 7, 0);
    run_plane(1'b0, dn);
    chk("p128_done", 32'(dn), 32'd1);
    exp_p1(1'b0, 1'b0);
    compare("p128");

    blk[0][0] = 9'h0C0;
    load_plane(1'b1, 7, 0);
    run_plane(1'b0, dn);
    exp_p1(1'b0, 1'b0);
    compare("p192_msb");
    load_plane(1'b0, 6, 0);
    run_plane(1'b0, dn);
    chk("p192_b6_done", 32'(dn), 32'd1);
    exp_p2(1'b0);
    compare("p192_b6");

    load_plane(1'b1, 7, 3);
    run_plane(1'b0, dn);
    exp_p1(1'b1, 1'b0);
    compare("hh_msb");
    load_plane(1'b0, 6, 3);
    run_plane(1'b0, dn);
    exp_p2(1'b1);
    compare("hh_b6");

    load_plane(1'b1, 7, 0);
    run_plane(1'b1, dn);
    exp_p1(1'b0, 1'b0);
    compare("noise_msb");
    load_plane(1'b0, 6, 0);
    run_plane(1'b1, dn);
    chk("noise_done", 32'(dn), 32'd1);
    exp_p2(1'b0);
    compare("noise_b6");

    mq_cln_e = 1'b0;
    load_plane(1'b1, 7, 0);
    run_plane(1'b0, dn);
    chk("cln_off_done", 32'(dn), 32'd1);
    compare("cln_off");
    mq_cln_e = 1'b1;
    load_plane(1'b0, 6, 0);
    run_plane(1'b0, dn);
    exp_p2(1'b0);
    compare("after_cln_off");

    blk[0][0] = 9'h180;
    load_plane(1'b1, 7, 0);
    run_plane(1'b0, dn);
    exp_p1(1'b0, 1'b1);
    compare("neg_msb");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
